// File: rtl/quad_dp_pkg.sv
// Shared definitions for the polynomial datapath: widths, control-word layout
// and ALU / operand-select encodings.
package quad_dp_pkg;

   localparam int unsigned BITS   = 9;
   localparam int unsigned CTRL_W = 15;
   localparam int unsigned SEL_W  = 2;

   // Control word bit positions (multi-bit fields give their LSB)
   localparam int unsigned CTRL_LD_IN   = 14;
   localparam int unsigned CTRL_LD_T1   = 13;
   localparam int unsigned CTRL_LD_T2   = 12;
   localparam int unsigned CTRL_SRC_A   = 10;
   localparam int unsigned CTRL_SRC_B   = 8;
   localparam int unsigned CTRL_ALU_OP  = 6;
   localparam int unsigned CTRL_LD_Y    = 5;
   localparam int unsigned CTRL_CLR_OVF = 4;
   localparam int unsigned CTRL_SAT_EN  = 3;
   localparam int unsigned CTRL_HOLD    = 2;
   localparam int unsigned CTRL_RSVD    = 0;
   localparam int unsigned CTRL_RSVD_W  = 2;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_PASS = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_A_RA = 2'b00,
      SRC_A_RB = 2'b01,
      SRC_A_RX = 2'b10,
      SRC_A_T1 = 2'b11
   } src_a_e;

   typedef enum logic [1:0] {
      SRC_B_RX = 2'b00,
      SRC_B_RC = 2'b01,
      SRC_B_T1 = 2'b10,
      SRC_B_T2 = 2'b11
   } src_b_e;

endpackage

// File: rtl/quad_dp_if.sv
// Operand, control and result bundle between the controller and the datapath.
interface quad_dp_if #(parameter int unsigned BITS = quad_dp_pkg::BITS);
   import quad_dp_pkg::*;

   logic [BITS-1:0]   in_a;
   logic [BITS-1:0]   in_b;
   logic [BITS-1:0]   in_c;
   logic [BITS-1:0]   in_x;
   logic [CTRL_W-1:0] control;
   logic              done;
   logic [BITS-1:0]   y_out;
   logic              out_valid;
   logic              ovf;

   modport master (
      output in_a, in_b, in_c, in_x, control, done,
      input  y_out, out_valid, ovf
   );

   modport slave (
      input  in_a, in_b, in_c, in_x, control, done,
      output y_out, out_valid, ovf
   );

endinterface

// File: rtl/quad_dp_alu.sv
// Shared unsigned ALU: add/sub/mul/pass with overflow detect and optional clamp.
module quad_alu #(
   parameter int unsigned BITS = quad_dp_pkg::BITS
) (
   input  logic [BITS-1:0]     a,
   input  logic [BITS-1:0]     b,
   input  quad_dp_pkg::alu_op_e op,
   input  logic                sat_en,
   output logic [BITS-1:0]     result,
   output logic                ovf_now
);
   import quad_dp_pkg::*;

   localparam int unsigned PW = 2 * BITS;
   localparam logic [BITS-1:0] MAX_VAL = '1;

   logic [BITS:0] sum;
   logic [BITS:0] diff;
   logic [PW-1:0] prod;

   // Wide intermediates keep the carry, borrow and upper product bits
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      prod    = PW'(a) * PW'(b);
      result  = a;
      ovf_now = 1'b0;
      case (op)
         OP_ADD: begin
            ovf_now = sum[BITS];
            result  = (ovf_now && sat_en) ? MAX_VAL : sum[BITS-1:0];
         end
         OP_SUB: begin
            ovf_now = diff[BITS];
            result  = (ovf_now && sat_en) ? '0 : diff[BITS-1:0];
         end
         OP_MUL: begin
            ovf_now = |prod[PW-1:BITS];
            result  = (ovf_now && sat_en) ? MAX_VAL : prod[BITS-1:0];
         end
         OP_PASS: begin
            ovf_now = 1'b0;
            result  = a;
         end
      endcase
   end

endmodule

// File: rtl/quad_datapath.sv
// Polynomial datapath: operand/temporary registers around a shared ALU, with a
// registered result, a done-delayed valid pulse and a sticky overflow flag.
module quad_datapath #(
   parameter int unsigned BITS = quad_dp_pkg::BITS
) (
   input  logic      clk,
   input  logic      rst,
   quad_dp_if.slave  dp
);
   import quad_dp_pkg::*;

   logic [BITS-1:0] ra, rb, rc, rx, t1, t2, y_q;
   logic            valid_q, ovf_q;

   logic    ld_in, ld_t1, ld_t2, ld_y, clr_ovf, sat_en, hold;
   src_a_e  src_a;
   src_b_e  src_b;
   alu_op_e alu_op;
   logic    ctrl_unused;

   logic [BITS-1:0] opa_c, opb_c, alu_res_c;
   logic            alu_ovf_c, ovf_set_c;

   assign ld_in   = dp.control[CTRL_LD_IN];
   assign ld_t1   = dp.control[CTRL_LD_T1];
   assign ld_t2   = dp.control[CTRL_LD_T2];
   assign ld_y    = dp.control[CTRL_LD_Y];
   assign clr_ovf = dp.control[CTRL_CLR_OVF];
   assign sat_en  = dp.control[CTRL_SAT_EN];
   assign hold    = dp.control[CTRL_HOLD];
   assign src_a   = src_a_e'(dp.control[CTRL_SRC_A +: SEL_W]);
   assign src_b   = src_b_e'(dp.control[CTRL_SRC_B +: SEL_W]);
   assign alu_op  = alu_op_e'(dp.control[CTRL_ALU_OP +: SEL_W]);
   assign ctrl_unused = ^dp.control[CTRL_RSVD +: CTRL_RSVD_W];

   // Operand selection always reads pre-edge register contents
   always_comb begin
      opa_c = ra;
      opb_c = rx;
      case (src_a)
         SRC_A_RA: opa_c = ra;
         SRC_A_RB: opa_c = rb;
         SRC_A_RX: opa_c = rx;
         SRC_A_T1: opa_c = t1;
      endcase
      case (src_b)
         SRC_B_RX: opb_c = rx;
         SRC_B_RC: opb_c = rc;
         SRC_B_T1: opb_c = t1;
         SRC_B_T2: opb_c = t2;
      endcase
   end

   quad_alu #(.BITS(BITS)) u_alu (
      .a       (opa_c),
      .b       (opb_c),
      .op      (alu_op),
      .sat_en  (sat_en),
      .result  (alu_res_c),
      .ovf_now (alu_ovf_c)
   );

   assign ovf_set_c = (ld_t1 | ld_t2 | ld_y) & alu_ovf_c;

   // hold freezes every register except the done-to-valid delay
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra      <= '0;
         rb      <= '0;
         rc      <= '0;
         rx      <= '0;
         t1      <= '0;
         t2      <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= dp.done;
         if (!hold) begin
            if (ld_in) begin
               ra <= dp.in_a;
               rb <= dp.in_b;
               rc <= dp.in_c;
               rx <= dp.in_x;
            end
            if (ld_t1) t1  <= alu_res_c;
            if (ld_t2) t2  <= alu_res_c;
            if (ld_y)  y_q <= alu_res_c;
            if (ovf_set_c)    ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
         end
      end
   end

   assign dp.y_out     = y_q;
   assign dp.out_valid = valid_q;
   assign dp.ovf       = ovf_q;

endmodule

// File: tb/tb_quad_datapath.sv
// Self-checking bench for quad_datapath: directed table, corner sequences and
// randomized control words against an arithmetic reference model.
module tb_quad_datapath;

   localparam int unsigned W = 9;
   localparam int MAXV = 511;
   localparam int ADD = 0, SUB = 1, MUL = 2, PASS = 3;

   logic clk = 1'b0;
   logic rst;

   quad_dp_if #(.BITS(W)) bus ();

   quad_datapath #(.BITS(W)) dut (
      .clk (clk),
      .rst (rst),
      .dp  (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   int m_ra, m_rb, m_rc, m_rx, m_t1, m_t2, m_y, m_valid, m_ovf;

   typedef struct {
      logic [14:0] w;
      int a, b, c, x;
      bit done;
      int y, valid, ovf, t1, t2;
   } vec_t;

   vec_t poly [7];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic logic [14:0] cw(input bit ld_in, input bit ld_t1, input bit ld_t2,
                                      input int sa, input int sb, input int op,
                                      input bit ld_y, input bit clr, input bit sat,
                                      input bit hold);
      logic [14:0] w;
      w = '0;
      w[14]    = ld_in;
      w[13]    = ld_t1;
      w[12]    = ld_t2;
      w[11:10] = 2'(sa);
      w[9:8]   = 2'(sb);
      w[7:6]   = 2'(op);
      w[5]     = ld_y;
      w[4]     = clr;
      w[3]     = sat;
      w[2]     = hold;
      return w;
   endfunction

   // Arithmetic reference: exact integer result, then clamp or wrap
   function automatic void ref_alu(input int a, input int b, input int op, input bit sat,
                                   output int r, output bit o);
      int raw;
      case (op)
         ADD:     begin raw = a + b; o = (raw > MAXV); end
         SUB:     begin raw = a - b; o = (a < b);      end
         MUL:     begin raw = a * b; o = (raw > MAXV); end
         default: begin raw = a;     o = 1'b0;         end
      endcase
      if (o && sat) r = (op == SUB) ? 0 : MAXV;
      else          r = raw & MAXV;
   endfunction

   function automatic void model_reset();
      m_ra = 0; m_rb = 0; m_rc = 0; m_rx = 0;
      m_t1 = 0; m_t2 = 0; m_y = 0; m_valid = 0; m_ovf = 0;
   endfunction

   function automatic void model_step(input logic [14:0] w, input int a, input int b,
                                      input int c, input int x, input bit done);
      int va, vb, r;
      bit o;
      case (int'(w[11:10]))
         0: va = m_ra;  1: va = m_rb;  2: va = m_rx;  default: va = m_t1;
      endcase
      case (int'(w[9:8]))
         0: vb = m_rx;  1: vb = m_rc;  2: vb = m_t1;  default: vb = m_t2;
      endcase
      ref_alu(va, vb, int'(w[7:6]), w[3], r, o);
      if (!w[2]) begin
         if (w[13]) m_t1 = r;
         if (w[12]) m_t2 = r;
         if (w[5])  m_y  = r;
         if ((w[13] || w[12] || w[5]) && o) m_ovf = 1;
         else if (w[4])                     m_ovf = 0;
         if (w[14]) begin m_ra = a; m_rb = b; m_rc = c; m_rx = x; end
      end
      m_valid = done;
   endfunction

   task automatic apply(input logic [14:0] w, input int a, input int b, input int c,
                        input int x, input bit done);
      bus.control = w;
      bus.in_a = W'(a);
      bus.in_b = W'(b);
      bus.in_c = W'(c);
      bus.in_x = W'(x);
      bus.done = done;
      @(posedge clk);
      #1;
      model_step(w, a, b, c, x, done);
      check("model_y",     int'(bus.y_out),     m_y);
      check("model_valid", int'(bus.out_valid), m_valid);
      check("model_ovf",   int'(bus.ovf),       m_ovf);
      check("model_t1",    int'(dut.t1),        m_t1);
      check("model_t2",    int'(dut.t2),        m_t2);
      check("model_ra",    int'(dut.ra),        m_ra);
   endtask

   task automatic run_poly(input int n);
      for (int i = 0; i < n; i++) begin
         apply(poly[i].w, poly[i].a, poly[i].b, poly[i].c, poly[i].x, poly[i].done);
         check($sformatf("poly%0d_y", i),     int'(bus.y_out),     poly[i].y);
         check($sformatf("poly%0d_valid", i), int'(bus.out_valid), poly[i].valid);
         check($sformatf("poly%0d_ovf", i),   int'(bus.ovf),       poly[i].ovf);
         check($sformatf("poly%0d_t1", i),    int'(dut.t1),        poly[i].t1);
         check($sformatf("poly%0d_t2", i),    int'(dut.t2),        poly[i].t2);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int pick();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return MAXV;
         default: return int'($urandom_range(0, MAXV));
      endcase
   endfunction

   initial begin
      logic [14:0] w;

      //            w                                       a  b  c  x  dn  y vld ovf t1  t2
      poly[0] = '{cw(1,0,0, 0,0,ADD,  0,0,0,0),             2, 3, 5, 4, 0,  0, 0, 0,  0,  0};
      poly[1] = '{cw(0,1,0, 0,0,MUL,  0,0,0,0),             0, 0, 0, 0, 0,  0, 0, 0,  8,  0};
      poly[2] = '{cw(0,1,0, 3,0,MUL,  0,0,0,0),             0, 0, 0, 0, 0,  0, 0, 0, 32,  0};
      poly[3] = '{cw(0,0,1, 1,0,MUL,  0,0,0,0),             0, 0, 0, 0, 0,  0, 0, 0, 32, 12};
      poly[4] = '{cw(0,1,0, 3,3,ADD,  0,0,0,0),             0, 0, 0, 0, 0,  0, 0, 0, 44, 12};
      poly[5] = '{cw(0,0,0, 3,1,ADD,  1,0,0,0),             0, 0, 0, 0, 1, 49, 1, 0, 44, 12};
      poly[6] = '{cw(0,0,0, 0,0,ADD,  0,0,0,0),             0, 0, 0, 0, 0, 49, 0, 0, 44, 12};

      rst = 1'b1;
      bus.control = '0;
      bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_x = '0;
      bus.done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_y",     int'(bus.y_out),     0);
      check("rst_valid", int'(bus.out_valid), 0);
      check("rst_ovf",   int'(bus.ovf),       0);
      check("rst_t1",    int'(dut.t1),        0);
      @(negedge clk);
      rst = 1'b0;

      run_poly(7);

      // Multiply overflow: wrap, then clamp, then clear
      apply(cw(1,0,0, 0,0,ADD, 0,0,0,0), 511, 0, 0, 2, 0);
      apply(cw(0,1,0, 0,0,MUL, 0,0,0,0), 0, 0, 0, 0, 0);
      check("mulwrap_t1",  int'(dut.t1),  510);
      check("mulwrap_ovf", int'(bus.ovf), 1);
      apply(cw(0,1,0, 0,0,MUL, 0,0,1,0), 0, 0, 0, 0, 0);
      check("mulsat_t1",   int'(dut.t1),  511);
      check("mulsat_ovf",  int'(bus.ovf), 1);
      apply(cw(0,0,0, 0,0,ADD, 0,1,0,0), 0, 0, 0, 0, 0);
      check("clr_ovf",     int'(bus.ovf), 0);

      // Subtract underflow: 3 - 5
      apply(cw(1,0,0, 0,0,ADD, 0,0,0,0), 0, 3, 5, 0, 0);
      apply(cw(0,0,0, 1,1,SUB, 1,0,0,0), 0, 0, 0, 0, 0);
      check("subwrap_y",   int'(bus.y_out), 510);
      check("subwrap_ovf", int'(bus.ovf),   1);
      apply(cw(0,0,0, 0,0,ADD, 0,1,0,0), 0, 0, 0, 0, 0);
      apply(cw(0,0,0, 1,1,SUB, 1,0,1,0), 0, 0, 0, 0, 0);
      check("subsat_y",    int'(bus.y_out), 0);
      check("subsat_ovf",  int'(bus.ovf),   1);

      // Set beats a same-cycle clear
      apply(cw(1,0,0, 0,0,ADD, 0,1,0,0), 511, 0, 0, 2, 0);
      check("prio_pre_ovf", int'(bus.ovf), 0);
      apply(cw(0,1,0, 0,0,MUL, 0,1,0,0), 0, 0, 0, 0, 0);
      check("prio_ovf",     int'(bus.ovf), 1);

      // hold freezes ld_in, ld_y and clr_ovf
      apply(cw(1,0,0, 0,0,PASS, 1,1,0,1), 100, 100, 100, 100, 0);
      check("hold_y",   int'(bus.y_out), 0);
      check("hold_ovf", int'(bus.ovf),   1);
      check("hold_ra",  int'(dut.ra),    511);

      // Same-edge load: ALU sees the old operands
      apply(cw(1,0,0, 0,0,ADD, 0,0,0,0), 2, 0, 0, 4, 0);
      apply(cw(1,1,0, 0,0,MUL, 0,0,0,0), 7, 0, 0, 4, 0);
      check("hazard_t1", int'(dut.t1), 8);
      check("hazard_ra", int'(dut.ra), 7);

      // Level done gives level out_valid
      for (int i = 0; i < 3; i++) begin
         apply('0, 0, 0, 0, 0, 1);
         check($sformatf("done_lvl%0d", i), int'(bus.out_valid), 1);
      end
      apply('0, 0, 0, 0, 0, 0);
      check("done_drop", int'(bus.out_valid), 0);

      // Asynchronous reset between cycles 4 and 5, then a fresh run
      do_reset();
      run_poly(4);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("async_y",     int'(bus.y_out),     0);
      check("async_valid", int'(bus.out_valid), 0);
      check("async_ovf",   int'(bus.ovf),       0);
      check("async_t1",    int'(dut.t1),        0);
      check("async_t2",    int'(dut.t2),        0);
      check("async_ra",    int'(dut.ra),        0);
      @(posedge clk);
      #1;
      check("async_novalid", int'(bus.out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      run_poly(7);

      // Random control words against the reference model
      for (int i = 0; i < 600; i++) begin
         w = 15'($urandom);
         w[2] = ($urandom_range(0, 7) == 0);
         apply(w, pick(), pick(), pick(), pick(), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
